pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the pipelined 8-bit core (IF/ID/EX/MEM/WB).
//  Tracks in-flight destination registers in a DEPTH-entry scoreboard shift register and drives the EX operand forward selects.
//  Also generates load-use stall, branch flush with bubble insertion, and a halt drain FSM, with saturating stall/flush counters.
//  Replaces the fixed two-source forwarding/hazard pair; sits beside the datapath and is fed decoded ID-stage fields.
// PARAMETERS
//  REG_AW      3  register address width
//  DEPTH       3  scoreboard entries after ID (0=EX,1=MEM,2=WB); forwardable results
//  LOAD_READY  1  first entry index whose load data can be forwarded; load at k<LOAD_READY => stall
//  ZERO_REG    0  1: register 0 is hardwired and never matches
//  CNT_W       16 perf counter width
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous reset, active-low
//  id_valid      in   1            ID holds a real instruction
//  id_src1/2     in   REG_AW       source register addresses
//  id_src1/2_used in  1            source is actually read
//  id_dest       in   REG_AW       destination register
//  id_wr_en      in   1            instruction writes the register file
//  id_is_load    in   1            instruction is a memory load
//  id_is_halt    in   1            instruction is HALT
//  ex_branch_taken in 1            EX resolved a taken branch/jump this cycle
//  fwd_sel_a/b   out  SW=$clog2(DEPTH+1)  0=register file, k+1=result of entry k
//  stall         out  1            hold PC and IF/ID register
//  flush_if_id   out  1            squash IF/ID contents
//  bubble_id_ex  out  1            insert NOP into ID/EX
//  draining      out  1            FSM in DRAIN
//  halted        out  1            FSM in HALTED
//  stall_cnt     out  CNT_W        saturating count of stall cycles
//  flush_cnt     out  CNT_W        saturating count of flush cycles
// BEHAVIOUR
//  Reset (async, rst=0): all entries invalid, FSM=RUN, counters 0; hence all outputs 0.
//  Entry = {valid, wr_en, dest, is_load}. Every rising edge: entry[i]<=entry[i-1] for i>=1.
//   entry[0]<=ID fields if id_valid & ~bubble_id_ex, else invalid.
//  Match(k,src): entry[k].valid & wr_en & dest==src & src_used & ~(ZERO_REG & src==0).
//  fwd_sel_x: smallest matching k gives k+1 (youngest wins); no match gives 0. Combinational, same cycle.
//  stall = (any source matches a load at k<LOAD_READY, youngest-match only) & ~ex_branch_taken & state==RUN.
//  flush_if_id = ex_branch_taken (one cycle per taken branch).
//  bubble_id_ex = stall | ex_branch_taken | state!=RUN.
//  Simultaneous branch_taken + load-use: flush wins, stall=0 (the stalled instruction is wrong-path).
//  HALT in ID with branch_taken in the same cycle: HALT is squashed and ignored.
//  FSM RUN->DRAIN: id_valid & id_is_halt & ~ex_branch_taken; HALT itself enters entry[0].
//   In DRAIN and HALTED: stall=1 (fetch frozen), no new entries.
//   DRAIN->HALTED when all entries are invalid; HALTED exits only via reset.
//  Counters increment by 1 per cycle with stall (RUN only) / flush_if_id high; saturate at all-ones, no wrap.
//  Latency: forward/stall decisions 0 cycles; scoreboard update 1 cycle.
// STRUCTURE
//  Shared package pipeline_ctrl_pkg:
//   - state encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2
//   - scoreboard entry struct/width macro
//   - fwd_sel encoding constants
//  One sub-module, operand_fwd_match (instantiated per source):
//   - priority-encodes entries into fwd_sel plus a load-hazard flag
//  Scoreboard, FSM and counters stay in the top level.
// TESTING
//  1. ADD r1 then ADD r2,r1,r3 back-to-back -> fwd_sel_a=1 next cycle; one gap -> 2; two gaps -> 3; three -> 0.
//  2. LOAD r4 then ADD r5,r4 -> stall=1 and bubble=1 for exactly 1 cycle, then fwd_sel_a=2, stall_cnt=1.
//  3. LOAD r4 in EX-match case with ex_branch_taken=1 in the same cycle -> stall=0, flush_if_id=1, flush_cnt=1.
//  4. r1 written by both entry0 and entry1, source r1 -> fwd_sel=1; ZERO_REG=1 with dest/src r0 -> fwd_sel=0.
//  5. HALT after two writers -> draining=1 for 3 cycles, then halted=1 permanently, stall held 1.
//     Assert rst=0 mid-DRAIN -> all outputs 0 immediately.
//  6. CNT_W=2, 5 consecutive stall cycles -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
// Scoreboard entries are packed vectors {valid, wr_en, dest, is_load}; helpers give field positions.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } ctrl_state_e;

   // fwd_sel: 0 selects the register file, k+1 selects the result held in entry k
   localparam int FWD_SEL_RF         = 0;
   localparam int FWD_SEL_ENTRY_BASE = 1;

   localparam int SB_LOAD_BIT = 0;
   localparam int SB_DEST_LSB = 1;

   function automatic int sb_entry_w(input int reg_aw);
      return reg_aw + 3;
   endfunction

   function automatic int sb_dest_msb(input int reg_aw);
      return reg_aw;
   endfunction

   function automatic int sb_wr_bit(input int reg_aw);
      return reg_aw + 1;
   endfunction

   function automatic int sb_valid_bit(input int reg_aw);
      return reg_aw + 2;
   endfunction

   function automatic int fwd_sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/operand_fwd_match.sv
// Priority-encodes the scoreboard for one source operand: youngest matching entry wins.
// Also flags a load-use hazard when that youngest match is a load not yet forwardable.
module operand_fwd_match
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW     = 3,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 1,
   parameter int ZERO_REG   = 0,
   localparam int EW        = sb_entry_w(REG_AW),
   localparam int SW        = fwd_sel_w(DEPTH)
) (
   input  logic [DEPTH*EW-1:0] entries_i,
   input  logic [REG_AW-1:0]   src_i,
   input  logic                src_used_i,
   output logic [SW-1:0]       fwd_sel_o,
   output logic                load_haz_o
);

   localparam int VB = sb_valid_bit(REG_AW);
   localparam int WB = sb_wr_bit(REG_AW);
   localparam int DM = sb_dest_msb(REG_AW);

   logic          src_ok;
   logic [EW-1:0] ent;

   assign src_ok = src_used_i & ~((ZERO_REG != 0) && (src_i == '0));

   // Scan oldest to youngest so the last hit (smallest k) wins.
   always_comb begin
      fwd_sel_o  = SW'(FWD_SEL_RF);
      load_haz_o = 1'b0;
      ent        = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         ent = entries_i[k*EW +: EW];
         if (src_ok && ent[VB] && ent[WB] && (ent[DM:SB_DEST_LSB] == src_i)) begin
            fwd_sel_o  = SW'(k + FWD_SEL_ENTRY_BASE);
            load_haz_o = ent[SB_LOAD_BIT] && (k < LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: in-flight destination scoreboard, EX forward selects,
// load-use stall, branch flush, halt drain FSM and saturating stall/flush counters.
//
// state     | meaning
// ST_RUN    | normal issue; stalls only on load-use hazards
// ST_DRAIN  | HALT issued; fetch frozen while older work retires
// ST_HALTED | scoreboard empty; stays here until reset
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW     = 3,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 1,
   parameter int ZERO_REG   = 0,
   parameter int CNT_W      = 16,
   localparam int SW        = fwd_sel_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_src1_used,
   input  logic              id_src2_used,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic              id_is_halt,
   input  logic              ex_branch_taken,
   output logic [SW-1:0]     fwd_sel_a,
   output logic [SW-1:0]     fwd_sel_b,
   output logic              stall,
   output logic              flush_if_id,
   output logic              bubble_id_ex,
   output logic              draining,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int EW = sb_entry_w(REG_AW);
   localparam int VB = sb_valid_bit(REG_AW);

   ctrl_state_e          state_q;
   logic                 draining_q;
   logic                 halted_q;
   logic [DEPTH*EW-1:0]  sb_q;
   logic [DEPTH*EW-1:0]  sb_d;
   logic [CNT_W-1:0]     stall_cnt_q;
   logic [CNT_W-1:0]     flush_cnt_q;

   logic haz_a;
   logic haz_b;
   logic in_run;
   logic load_use;
   logic issue;
   logic halt_go;
   logic sb_empty_d;

   operand_fwd_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .ZERO_REG   (ZERO_REG)
   ) u_match_a (
      .entries_i  (sb_q),
      .src_i      (id_src1),
      .src_used_i (id_src1_used),
      .fwd_sel_o  (fwd_sel_a),
      .load_haz_o (haz_a)
   );

   operand_fwd_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .ZERO_REG   (ZERO_REG)
   ) u_match_b (
      .entries_i  (sb_q),
      .src_i      (id_src2),
      .src_used_i (id_src2_used),
      .fwd_sel_o  (fwd_sel_b),
      .load_haz_o (haz_b)
   );

   // A taken branch squashes the stalled instruction, so flush overrides load-use.
   assign in_run       = (state_q == ST_RUN);
   assign load_use     = (haz_a | haz_b) & ~ex_branch_taken;
   assign stall        = ~in_run | load_use;
   assign flush_if_id  = ex_branch_taken;
   assign bubble_id_ex = stall | ex_branch_taken;
   assign issue        = id_valid & ~bubble_id_ex;

   // A stalled HALT is still waiting in ID and has not issued yet.
   assign halt_go = id_valid & id_is_halt & ~ex_branch_taken & ~load_use;

   always_comb begin
      sb_d = '0;
      if (issue) begin
         sb_d[EW-1:0] = {1'b1, id_wr_en, id_dest, id_is_load};
      end
      for (int i = 1; i < DEPTH; i++) begin
         sb_d[i*EW +: EW] = sb_q[(i-1)*EW +: EW];
      end
   end

   always_comb begin
      sb_empty_d = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (sb_d[i*EW + VB]) begin
            sb_empty_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   // Leave DRAIN on the edge that empties the scoreboard, so HALTED implies empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         draining_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (halt_go) begin
                  state_q    <= ST_DRAIN;
                  draining_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (sb_empty_d) begin
                  state_q    <= ST_HALTED;
                  draining_q <= 1'b0;
                  halted_q   <= 1'b1;
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q    <= ST_RUN;
               draining_q <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (in_run && load_use && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_if_id && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign draining  = draining_q;
   assign halted    = halted_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance and a ZERO_REG=1 / CNT_W=2
// instance share one stimulus stream; expected values are hand-computed per cycle.
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_src1;
   logic [2:0] id_src2;
   logic       id_src1_used;
   logic       id_src2_used;
   logic [2:0] id_dest;
   logic       id_wr_en;
   logic       id_is_load;
   logic       id_is_halt;
   logic       ex_branch_taken;

   logic [1:0]  fwd_a, fwd_b, z_fwd_a, z_fwd_b;
   logic        stall, flush, bubble, draining, halted;
   logic        z_stall, z_flush, z_bubble, z_draining, z_halted;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  z_stall_cnt, z_flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_hazard_ctrl u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_src1_used    (id_src1_used),
      .id_src2_used    (id_src2_used),
      .id_dest         (id_dest),
      .id_wr_en        (id_wr_en),
      .id_is_load      (id_is_load),
      .id_is_halt      (id_is_halt),
      .ex_branch_taken (ex_branch_taken),
      .fwd_sel_a       (fwd_a),
      .fwd_sel_b       (fwd_b),
      .stall           (stall),
      .flush_if_id     (flush),
      .bubble_id_ex    (bubble),
      .draining        (draining),
      .halted          (halted),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   pipeline_hazard_ctrl #(.ZERO_REG(1), .CNT_W(2)) u_dut_z (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_src1_used    (id_src1_used),
      .id_src2_used    (id_src2_used),
      .id_dest         (id_dest),
      .id_wr_en        (id_wr_en),
      .id_is_load      (id_is_load),
      .id_is_halt      (id_is_halt),
      .ex_branch_taken (ex_branch_taken),
      .fwd_sel_a       (z_fwd_a),
      .fwd_sel_b       (z_fwd_b),
      .stall           (z_stall),
      .flush_if_id     (z_flush),
      .bubble_id_ex    (z_bubble),
      .draining        (z_draining),
      .halted          (z_halted),
      .stall_cnt       (z_stall_cnt),
      .flush_cnt       (z_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_id(input logic v, input logic [2:0] s1, input logic u1,
                         input logic [2:0] s2, input logic u2, input logic [2:0] d,
                         input logic we, input logic ld, input logic hl, input logic br);
      id_valid        = v;
      id_src1         = s1;
      id_src1_used    = u1;
      id_src2         = s2;
      id_src2_used    = u2;
      id_dest         = d;
      id_wr_en        = we;
      id_is_load      = ld;
      id_is_halt      = hl;
      ex_branch_taken = br;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic writer(input logic [2:0] d);
      set_id(1, 0, 0, 0, 0, d, 1, 0, 0, 0);
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #12;
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_stall", stall, 0);
      chk("rst_bubble", bubble, 0);
      chk("rst_draining", draining, 0);
      chk("rst_halted", halted, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      rst = 1'b1;
      nx();

      // forwarding distance: 0..3 gaps
      writer(1); nx();
      set_id(1, 1, 1, 3, 1, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("gap0_fwd_a", fwd_a, 1);
      chk("gap0_fwd_b", fwd_b, 0);
      nx();
      writer(2); nx(); idle(); nx();
      set_id(1, 0, 0, 2, 1, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("gap1_fwd_b", fwd_b, 2);
      chk("gap1_fwd_a", fwd_a, 0);
      nx();
      writer(3); nx(); idle(); nx(); idle(); nx();
      set_id(1, 3, 1, 0, 0, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("gap2_fwd_a", fwd_a, 3);
      nx();
      writer(6); nx(); idle(); nx(); idle(); nx(); idle(); nx();
      set_id(1, 6, 1, 0, 0, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("gap3_fwd_a", fwd_a, 0);
      nx();

      // load-use stall for one cycle, then forward from MEM
      set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); nx();
      set_id(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
      @(negedge clk);
      chk("lu_stall", stall, 1);
      chk("lu_bubble", bubble, 1);
      nx();
      @(negedge clk);
      chk("lu_stall_after", stall, 0);
      chk("lu_bubble_after", bubble, 0);
      chk("lu_fwd_a_after", fwd_a, 2);
      chk("lu_stall_cnt", stall_cnt, 1);
      nx();

      // load-use coinciding with taken branch: flush wins
      set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); nx();
      set_id(1, 4, 1, 0, 0, 5, 1, 0, 0, 1);
      @(negedge clk);
      chk("br_stall", stall, 0);
      chk("br_flush", flush, 1);
      chk("br_bubble", bubble, 1);
      nx();
      idle();
      @(negedge clk);
      chk("br_flush_off", flush, 0);
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_z_flush_cnt", z_flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 1);
      nx();

      // four more load-use stalls: 5 total, 2-bit counter saturates at 3
      for (int i = 0; i < 4; i++) begin
         set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); nx();
         set_id(1, 0, 0, 4, 1, 5, 1, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("sat_stall_%0d", i), stall, 1);
         nx(); nx();
      end
      idle();
      @(negedge clk);
      chk("sat_stall_cnt16", stall_cnt, 5);
      chk("sat_stall_cnt2", z_stall_cnt, 3);
      nx();

      // youngest writer wins; r0 never matches when hardwired
      writer(1); nx(); writer(1); nx();
      set_id(1, 1, 1, 0, 0, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("young_fwd_a", fwd_a, 1);
      nx();
      writer(0); nx();
      set_id(1, 0, 1, 0, 0, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("r0_fwd_a_nz", fwd_a, 1);
      chk("r0_fwd_a_zreg", z_fwd_a, 0);
      nx();

      // HALT after two writers: 3 drain cycles, then halted for good
      writer(1); nx(); writer(2); nx();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("halt_id_draining", draining, 0);
      chk("halt_id_stall", stall, 0);
      nx();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("drain_%0d", i), draining, 1);
         chk($sformatf("drain_halted_%0d", i), halted, 0);
         chk($sformatf("drain_stall_%0d", i), stall, 1);
         nx();
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("halted_%0d", i), halted, 1);
         chk($sformatf("halted_draining_%0d", i), draining, 0);
         chk($sformatf("halted_stall_%0d", i), stall, 1);
         chk($sformatf("halted_bubble_%0d", i), bubble, 1);
         nx();
      end
      chk("halt_stall_cnt", stall_cnt, 5);

      rst = 1'b0;
      #1;
      chk("rst2_halted", halted, 0);
      chk("rst2_stall", stall, 0);
      chk("rst2_stall_cnt", stall_cnt, 0);
      #2 rst = 1'b1;
      nx();

      // HALT squashed by a taken branch in the same cycle
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      chk("halt_br_flush", flush, 1);
      nx();
      idle();
      @(negedge clk);
      chk("halt_br_draining", draining, 0);
      chk("halt_br_stall", stall, 0);
      chk("halt_br_flush_cnt", flush_cnt, 1);
      nx();

      // async reset in the middle of DRAIN
      writer(1); nx();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); nx();
      idle();
      @(negedge clk);
      chk("mid_draining", draining, 1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_draining", draining, 0);
      chk("mid_rst_halted", halted, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_bubble", bubble, 0);
      chk("mid_rst_flush_cnt", flush_cnt, 0);
      chk("mid_rst_fwd_a", fwd_a, 0);
      #1 rst = 1'b1;
      nx(); nx();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
